pwm_sample_out: RTL and testbench
=================================

PWM_SAMPLE_OUT -- requirements
Module: pwm_sample_out

Interface
REQ-001 SHALL have parameter N_FRAC, default 7, meaning fractional bits of the signed Q0.N_FRAC sample (sample width N_FRAC+1).
REQ-002 SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have port enable_i  input  1  run request; 0 holds the block idle.
REQ-005 SHALL have port data_i  input  N_FRAC+1  signed sample from the sine generator output.
REQ-006 SHALL have port data_valid_strobe_i  input  1  one-cycle strobe qualifying data_i.
REQ-007 SHALL have port next_data_strobe_o  output  1  one-cycle request for the next sample; drives the generator's next-data strobe.
REQ-008 SHALL have port pwm_o  output  1  PWM waveform, duty proportional to the applied sample.
REQ-009 SHALL have port sample_o  output  N_FRAC+1  signed sample currently applied to pwm_o.
REQ-010 SHALL have port underrun_o  output  1  sticky flag: a period boundary passed with no sample available.

Function
REQ-011 SHALL contain a period counter cnt of N_FRAC+1 bits; period P = 2^(N_FRAC+1) cycles (256 at default).
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, READY.
REQ-013 IDLE: cnt held 0, pwm_o 0, next_data_strobe_o 0; enable_i=1 -> REQ at next edge, cnt=0, underrun_o cleared.
REQ-014 REQ: lasts exactly one cycle, next_data_strobe_o=1 only in this state, -> WAIT.
REQ-015 WAIT: data_valid_strobe_i=1 captures data_i into a pending register and -> READY.
REQ-016 In all non-IDLE states cnt SHALL increment by 1 per cycle, wrapping P-1 -> 0 (period boundary).
REQ-017 Boundary in READY: sample_o <= pending, duty <= pending XOR 2^N_FRAC (offset binary), -> REQ (so the request occurs in the cnt=0 cycle).
REQ-018 Boundary in WAIT without data_valid_strobe_i: underrun_o <= 1, sample_o/duty unchanged, stay WAIT, no new request issued.
REQ-019 Boundary in WAIT with data_valid_strobe_i in the same cycle: data_i SHALL load directly into sample_o/duty, -> REQ, underrun_o not set.
REQ-020 data_valid_strobe_i in IDLE, REQ or READY SHALL be ignored.
REQ-021 pwm_o SHALL equal (state != IDLE) AND (cnt < duty), driven from registers only (no combinational path from inputs).
REQ-022 Duty range: sample -2^N_FRAC -> 0 high cycles; 0 -> P/2; 2^N_FRAC-1 -> P-1 high cycles per period.
REQ-023 enable_i=0 in any non-IDLE state SHALL force IDLE at next edge; pending sample discarded; sample_o, duty and underrun_o retained.
REQ-024 Generator latency up to P-2 cycles from request to data SHALL cause no underrun.

Reset
REQ-025 rst_i=0 SHALL immediately (asynchronously) set state IDLE, cnt 0, pending 0, sample_o 0, duty 2^N_FRAC, pwm_o 0, next_data_strobe_o 0, underrun_o 0.
REQ-026 Release of rst_i SHALL take effect on the first rising edge after release; reset mid-period discards any outstanding request.

Verification
REQ-027 Assert rst_i=0 between clock edges while running -> all outputs 0 before the next edge, sample_o=0.
REQ-028 Enable; reply data_i=0x40 10 cycles after each strobe -> strobe every 256 cycles; from second period pwm_o high 192 of 256 cycles, sample_o=0x40, underrun_o=0.
REQ-029 Reply 0x80 then 0x7F -> pwm_o 0 high cycles, then 255 high cycles in respective following periods.
REQ-030 Withhold reply after strobe -> underrun_o=1 at boundary, duty unchanged, no second strobe; reply 0x20 later -> applied at next boundary, underrun_o stays 1.
REQ-031 Reply pulsed exactly in the cnt=255 cycle while WAIT -> sample applied from next cnt=0, strobe at that cnt=0, underrun_o=0.
REQ-032 Drop enable_i mid-period -> pwm_o 0 next cycle, late data_valid ignored; re-enable -> underrun_o cleared, strobe in first cycle, sample_o retained.

Source files
------------

// File: rtl/pwm_sample_out.sv
// Purpose: turns a stream of signed Q0.N_FRAC samples into a fixed-period PWM waveform, requesting one sample per period.
// Latency: a sample received in a period is applied at the next period boundary, or immediately if it arrives in the boundary cycle.
// Backpressure: one request per period; a late generator raises a sticky underrun flag and the last duty is held.
module pwm_sample_out #(
    parameter int N_FRAC = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [N_FRAC:0]   data_i,
    input  logic              data_valid_strobe_i,
    output logic              next_data_strobe_o,
    output logic              pwm_o,
    output logic [N_FRAC:0]   sample_o,
    output logic              underrun_o
);

    localparam logic [N_FRAC:0] MID     = {1'b1, {N_FRAC{1'b0}}};
    localparam logic [N_FRAC:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        READY
    } state_t;

    state_t          state, state_nxt;
    logic [N_FRAC:0] cnt, cnt_nxt;
    logic [N_FRAC:0] pending, pending_nxt;
    logic [N_FRAC:0] sample_nxt;
    logic [N_FRAC:0] duty, duty_nxt;
    logic            underrun_nxt;
    logic            boundary;

    assign boundary = (cnt == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= '0;
            sample_o   <= '0;
            duty       <= MID;
            underrun_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pending    <= pending_nxt;
            sample_o   <= sample_nxt;
            duty       <= duty_nxt;
            underrun_o <= underrun_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        pending_nxt  = pending;
        sample_nxt   = sample_o;
        duty_nxt     = duty;
        underrun_nxt = underrun_o;

        if (state == IDLE) begin
            cnt_nxt = '0;
            if (enable_i) begin
                state_nxt    = REQ;
                underrun_nxt = 1'b0;
            end
        end else if (!enable_i) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            pending_nxt = '0;
        end else begin
            case (state)
                REQ: state_nxt = WAIT;
                WAIT: begin
                    if (boundary) begin
                        // A sample arriving exactly on the boundary bypasses the pending register.
                        if (data_valid_strobe_i) begin
                            sample_nxt = data_i;
                            duty_nxt   = data_i ^ MID;
                            state_nxt  = REQ;
                        end else begin
                            underrun_nxt = 1'b1;
                        end
                    end else if (data_valid_strobe_i) begin
                        pending_nxt = data_i;
                        state_nxt   = READY;
                    end
                end
                READY: begin
                    if (boundary) begin
                        sample_nxt = pending;
                        duty_nxt   = pending ^ MID;
                        state_nxt  = REQ;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign next_data_strobe_o = (state == REQ);
    assign pwm_o              = (state != IDLE) && (cnt < duty);

endmodule

// File: tb/tb_pwm_sample_out.sv
// Directed bench for pwm_sample_out: period-accurate stimulus with hand-computed duty counts, underrun, enable-drop and async reset cases.
module tb_pwm_sample_out;

    localparam int NF = 7;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic [NF:0]   data_i;
    logic          data_valid_strobe_i;
    logic          next_data_strobe_o;
    logic          pwm_o;
    logic [NF:0]   sample_o;
    logic          underrun_o;

    int n_assert = 0;
    int n_fail   = 0;
    int highs;
    int strobes;

    pwm_sample_out #(.N_FRAC(NF)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .enable_i            (enable_i),
        .data_i              (data_i),
        .data_valid_strobe_i (data_valid_strobe_i),
        .next_data_strobe_o  (next_data_strobe_o),
        .pwm_o               (pwm_o),
        .sample_o            (sample_o),
        .underrun_o          (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one full period starting at the cnt=0 sample point; reply_at=-1 withholds the reply.
    task automatic run_period(input int reply_at, input logic [NF:0] val,
                              output int h, output int s);
        h = 0;
        s = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_o === 1'b1) h++;
            if (next_data_strobe_o === 1'b1) s++;
            data_valid_strobe_i = (i == reply_at);
            data_i              = (i == reply_at) ? val : '0;
            step();
        end
        data_valid_strobe_i = 1'b0;
        data_i              = '0;
    endtask

    initial begin
        rst_i               = 1'b0;
        enable_i            = 1'b0;
        data_i              = '0;
        data_valid_strobe_i = 1'b0;
        repeat (3) step();
        chk("rst_pwm",      pwm_o,              0);
        chk("rst_strobe",   next_data_strobe_o, 0);
        chk("rst_sample",   sample_o,           0);
        chk("rst_underrun", underrun_o,         0);

        rst_i = 1'b1;
        step();
        chk("idle_pwm",    pwm_o,              0);
        chk("idle_strobe", next_data_strobe_o, 0);

        enable_i = 1'b1;
        step();
        chk("first_strobe", next_data_strobe_o, 1);

        // Period 1 runs at the reset duty (midscale), reply 0x40 after 10 cycles
        run_period(10, 8'h40, highs, strobes);
        chk("p1_highs",   highs,   128);
        chk("p1_strobes", strobes, 1);
        chk("p1_sample",  sample_o, 8'h40);
        chk("p1_strobe_at_cnt0", next_data_strobe_o, 1);
        chk("p1_underrun", underrun_o, 0);

        run_period(10, 8'h80, highs, strobes);
        chk("p2_highs",   highs,   192);
        chk("p2_strobes", strobes, 1);
        chk("p2_sample",  sample_o, 8'h80);

        run_period(10, 8'h7F, highs, strobes);
        chk("p3_highs_min", highs, 0);
        chk("p3_sample",    sample_o, 8'h7F);

        // Reply withheld: underrun at the boundary, no new request
        run_period(-1, 8'h00, highs, strobes);
        chk("p4_highs_max", highs,   255);
        chk("p4_strobes",   strobes, 1);
        chk("p4_underrun",  underrun_o, 1);
        chk("p4_no_strobe", next_data_strobe_o, 0);
        chk("p4_sample",    sample_o, 8'h7F);

        run_period(100, 8'h20, highs, strobes);
        chk("p5_highs_held", highs,   255);
        chk("p5_strobes",    strobes, 0);
        chk("p5_sample",     sample_o, 8'h20);
        chk("p5_strobe",     next_data_strobe_o, 1);
        chk("p5_underrun_sticky", underrun_o, 1);

        // Drop enable mid-period, feed a stray sample while idle, then re-enable
        highs   = 0;
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            if (pwm_o === 1'b1) highs++;
            if (next_data_strobe_o === 1'b1) strobes++;
            step();
        end
        chk("p6_partial_highs",   highs,   100);
        chk("p6_partial_strobes", strobes, 1);
        enable_i = 1'b0;
        step();
        chk("dis_pwm",    pwm_o,              0);
        chk("dis_strobe", next_data_strobe_o, 0);
        data_valid_strobe_i = 1'b1;
        data_i              = 8'h55;
        step();
        data_valid_strobe_i = 1'b0;
        data_i              = '0;
        step();
        chk("dis_sample_kept",   sample_o,   8'h20);
        chk("dis_underrun_kept", underrun_o, 1);
        chk("dis_pwm_idle",      pwm_o,      0);
        enable_i = 1'b1;
        step();
        chk("reen_strobe",   next_data_strobe_o, 1);
        chk("reen_underrun", underrun_o,         0);
        chk("reen_sample",   sample_o,           8'h20);

        // Reply in the cnt=255 cycle loads straight into the output
        run_period(255, 8'h10, highs, strobes);
        chk("p7_highs",    highs,   160);
        chk("p7_strobes",  strobes, 1);
        chk("p7_sample",   sample_o, 8'h10);
        chk("p7_strobe",   next_data_strobe_o, 1);
        chk("p7_underrun", underrun_o, 0);

        // Worst tolerated latency: reply 254 cycles after the request
        run_period(254, 8'h30, highs, strobes);
        chk("p8_highs",    highs,   144);
        chk("p8_sample",   sample_o, 8'h30);
        chk("p8_underrun", underrun_o, 0);

        // Asynchronous reset between edges mid-period
        for (int i = 0; i < 50; i++) step();
        chk("pre_rst_pwm", pwm_o, 1);
        #3;
        rst_i = 1'b0;
        #1;
        chk("arst_pwm",      pwm_o,              0);
        chk("arst_strobe",   next_data_strobe_o, 0);
        chk("arst_sample",   sample_o,           0);
        chk("arst_underrun", underrun_o,         0);
        step();
        rst_i = 1'b1;
        step();
        chk("post_rst_strobe", next_data_strobe_o, 1);
        chk("post_rst_sample", sample_o, 0);

        run_period(10, 8'h40, highs, strobes);
        chk("p9_highs_reset_duty", highs, 128);
        chk("p9_sample", sample_o, 8'h40);

        run_period(10, 8'h00, highs, strobes);
        chk("p10_highs", highs, 192);
        chk("p10_sample", sample_o, 8'h00);
        chk("p10_underrun", underrun_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
